// File: rtl/y86_fetch_decode_exec_if.sv
// Signal bundle between the Y86-64 fetch/decode/execute block and its environment:
// fetch inputs, decoded/executed results, and the write-back port.
interface y86_fetch_decode_exec_if;
  logic [63:0] pc;
  logic [79:0] imem_bytes;
  logic [3:0]  icode;
  logic [3:0]  ifun;
  logic [3:0]  rA;
  logic [3:0]  rB;
  logic [63:0] valC;
  logic [63:0] valP;
  logic        instr_invalid;
  logic        imem_er;
  logic        hlt_er;
  logic [63:0] valA;
  logic [63:0] valB;
  logic [3:0]  dstE;
  logic [3:0]  dstM;
  logic [63:0] valE;
  logic        cnd;
  logic        zf;
  logic        sf;
  logic        of;
  logic        wb_en;
  logic [3:0]  wb_dstE;
  logic [3:0]  wb_dstM;
  logic [63:0] wb_valE;
  logic [63:0] wb_valM;

  modport master (
    output pc, imem_bytes, wb_en, wb_dstE, wb_dstM, wb_valE, wb_valM,
    input  icode, ifun, rA, rB, valC, valP, instr_invalid, imem_er, hlt_er,
           valA, valB, dstE, dstM, valE, cnd, zf, sf, of
  );

  modport slave (
    input  pc, imem_bytes, wb_en, wb_dstE, wb_dstM, wb_valE, wb_valM,
    output icode, ifun, rA, rB, valC, valP, instr_invalid, imem_er, hlt_er,
           valA, valB, dstE, dstM, valE, cnd, zf, sf, of
  );
endinterface

// File: rtl/y86_fetch_decode_exec.sv
// Fetch, decode and execute stages of a sequential Y86-64 core: combinational
// instruction parse, 15-entry register file, ALU and registered condition codes.
module y86_fetch_decode_exec #(
  parameter int unsigned IMEM_BYTES = 2048
) (
  input logic                    clk,
  input logic                    rst_n,
  y86_fetch_decode_exec_if.slave bus
);

  localparam logic [3:0] RNONE    = 4'hF;
  localparam logic [3:0] RSP      = 4'h4;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SUB  = 4'h1;
  localparam logic [3:0] ALU_AND  = 4'h2;
  localparam logic [3:0] ALU_XOR  = 4'h3;

  logic [63:0] regs [0:14];
  logic        zf_q, sf_q, of_q;

  logic [3:0]  icode, ifun, ra, rb, srca, srcb, dste, dstm;
  logic        need_reg, need_valc, instr_invalid, imem_er, hlt_er;
  logic        cond, cnd, lt, alu_of, cc_update;
  logic [63:0] valc, valp, vala, valb, vale;

  // ---------------- fetch ----------------
  assign icode = bus.imem_bytes[7:4];
  assign ifun  = bus.imem_bytes[3:0];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    need_reg  = 1'b0;
    need_valc = 1'b0;
    case (icode)
      I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ: need_reg = 1'b1;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: begin
        need_reg  = 1'b1;
        need_valc = 1'b1;
      end
      I_JXX, I_CALL: need_valc = 1'b1;
      default: ;
    endcase
  end

  assign ra   = need_reg ? bus.imem_bytes[15:12] : RNONE;
  assign rb   = need_reg ? bus.imem_bytes[11:8]  : RNONE;
  assign valc = !need_valc ? 64'd0 :
                need_reg   ? bus.imem_bytes[79:16] : bus.imem_bytes[71:8];
  assign valp = bus.pc + 64'd1 + {63'd0, need_reg} + (need_valc ? 64'd8 : 64'd0);

  always_comb begin
    instr_invalid = 1'b0;
    case (icode)
      I_RRMOVQ, I_JXX:            instr_invalid = (ifun > 4'd6);
      I_OPQ:                      instr_invalid = (ifun > 4'd3);
      4'hC, 4'hD, 4'hE, 4'hF:     instr_invalid = 1'b1;
      default:                    instr_invalid = (ifun != 4'd0);
    endcase
  end

  assign imem_er = (bus.pc >= 64'(IMEM_BYTES));
  assign hlt_er  = (icode == I_HALT);

  // ---------------- decode ----------------
  always_comb begin
    srca = RNONE;
    srcb = RNONE;
    case (icode)
      I_RRMOVQ, I_OPQ:  srca = ra;
      I_RMMOVQ:         begin srca = ra; srcb = rb; end
      I_MRMOVQ:         srcb = rb;
      I_PUSHQ:          begin srca = ra; srcb = RSP; end
      I_RET, I_POPQ:    begin srca = RSP; srcb = RSP; end
      I_CALL:           srcb = RSP;
      default: ;
    endcase
    if (icode == I_OPQ) srcb = rb;
  end

  // Index 0xF means "no register"; reads are not bypassed from the write port.
  assign vala = (srca == RNONE) ? 64'd0 : regs[srca];
  assign valb = (srcb == RNONE) ? 64'd0 : regs[srcb];

  always_comb begin
    dste = RNONE;
    dstm = RNONE;
    case (icode)
      I_IRMOVQ, I_OPQ:                  dste = rb;
      I_RRMOVQ:                         dste = cnd ? rb : RNONE;
      I_CALL, I_RET, I_PUSHQ:           dste = RSP;
      I_MRMOVQ:                         dstm = ra;
      I_POPQ:                           begin dste = RSP; dstm = ra; end
      default: ;
    endcase
  end

  // ---------------- execute ----------------
  always_comb begin
    lt   = sf_q ^ of_q;
    cond = 1'b0;
    case (ifun)
      4'd0: cond = 1'b1;
      4'd1: cond = lt | zf_q;
      4'd2: cond = lt;
      4'd3: cond = zf_q;
      4'd4: cond = ~zf_q;
      4'd5: cond = ~lt;
      4'd6: cond = ~lt & ~zf_q;
      default: cond = 1'b0;
    endcase
    cnd = cond & ((icode == I_RRMOVQ) || (icode == I_JXX));
  end

  always_comb begin
    vale   = 64'd0;
    alu_of = 1'b0;
    case (icode)
      I_RRMOVQ:           vale = vala;
      I_IRMOVQ:           vale = valc;
      I_RMMOVQ, I_MRMOVQ: vale = valb + valc;
      I_OPQ: begin
        case (ifun)
          ALU_ADD: begin
            vale   = valb + vala;
            alu_of = (vala[63] == valb[63]) && (vale[63] != valb[63]);
          end
          ALU_SUB: begin
            vale   = valb - vala;
            alu_of = (vala[63] != valb[63]) && (vale[63] != valb[63]);
          end
          ALU_AND: vale = valb & vala;
          ALU_XOR: vale = valb ^ vala;
          default: ;
        endcase
      end
      I_CALL, I_PUSHQ:    vale = valb - 64'd8;
      I_RET, I_POPQ:      vale = valb + 64'd8;
      default: ;
    endcase
  end

  assign cc_update = (icode == I_OPQ) && !instr_invalid && !imem_er && !hlt_er;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zf_q <= 1'b1;
      sf_q <= 1'b0;
      of_q <= 1'b0;
    end else if (cc_update) begin
      zf_q <= (vale == 64'd0);
      sf_q <= vale[63];
      of_q <= alu_of;
    end
  end

  // NOTE: the register file is architecturally cleared by reset, so this memory is reset
  // explicitly; the later M assignment overrides E when both target the same register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 15; i++) regs[i] <= 64'd0;
    end else if (bus.wb_en) begin
      if (bus.wb_dstE != RNONE) regs[bus.wb_dstE] <= bus.wb_valE;
      if (bus.wb_dstM != RNONE) regs[bus.wb_dstM] <= bus.wb_valM;
    end
  end

  assign bus.icode         = icode;
  assign bus.ifun          = ifun;
  assign bus.rA            = ra;
  assign bus.rB            = rb;
  assign bus.valC          = valc;
  assign bus.valP          = valp;
  assign bus.instr_invalid = instr_invalid;
  assign bus.imem_er       = imem_er;
  assign bus.hlt_er        = hlt_er;
  assign bus.valA          = vala;
  assign bus.valB          = valb;
  assign bus.dstE          = dste;
  assign bus.dstM          = dstm;
  assign bus.valE          = vale;
  assign bus.cnd           = cnd;
  assign bus.zf            = zf_q;
  assign bus.sf            = sf_q;
  assign bus.of            = of_q;

endmodule

// File: tb/tb_y86_fetch_decode_exec.sv
// Scoreboard bench: stimulus pushes model predictions, a negedge monitor pops and
// compares them against the fetch/decode/execute outputs.
module tb_y86_fetch_decode_exec;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  y86_fetch_decode_exec_if bus ();

  y86_fetch_decode_exec #(.IMEM_BYTES(2048)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0]  icode, ifun, ra, rb;
    logic [63:0] valc, valp;
    logic        inv, imem, hlt;
    logic [63:0] vala, valb;
    logic [3:0]  dste, dstm;
    logic [63:0] vale;
    logic        cnd, zf, sf, of, new_of;
  } exp_t;

  exp_t        sb [$];
  exp_t        mon_e;
  int          vectors = 0;
  int          miscompares = 0;

  // Architectural state of the reference model.
  logic [63:0] m_regs [15];
  logic        m_zf, m_sf, m_of;

  task automatic model_reset();
    for (int i = 0; i < 15; i++) m_regs[i] = 64'd0;
    m_zf = 1'b1;
    m_sf = 1'b0;
    m_of = 1'b0;
  endtask

  function automatic logic [63:0] rd(input logic [3:0] idx);
    return (idx == 4'hF) ? 64'd0 : m_regs[idx];
  endfunction

  function automatic exp_t model(input logic [63:0] pc_v, input logic [79:0] bv);
    exp_t e;
    logic [7:0] b [10];
    bit needreg, needc;
    logic [3:0] srca, srcb;
    logic lt;
    logic signed [63:0] sa, sbv, r;
    for (int k = 0; k < 10; k++) b[k] = bv[8*k +: 8];
    e.icode = b[0][7:4];
    e.ifun  = b[0][3:0];
    needreg = e.icode inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB};
    needc   = e.icode inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8};
    e.ra = needreg ? b[1][7:4] : 4'hF;
    e.rb = needreg ? b[1][3:0] : 4'hF;
    e.valc = 64'd0;
    if (needc)
      for (int k = 0; k < 8; k++) e.valc[8*k +: 8] = b[k + (needreg ? 2 : 1)];
    e.valp = pc_v + 64'(1 + (needreg ? 1 : 0) + (needc ? 8 : 0));
    if (e.icode > 4'hB)                      e.inv = 1'b1;
    else if (e.icode == 4'h6)                e.inv = (e.ifun > 4'd3);
    else if (e.icode inside {4'h2, 4'h7})    e.inv = (e.ifun > 4'd6);
    else                                     e.inv = (e.ifun != 4'd0);
    e.imem = (pc_v >= 64'd2048);
    e.hlt  = (e.icode == 4'h0);

    srca = 4'hF;
    srcb = 4'hF;
    if (e.icode inside {4'h2, 4'h4, 4'h6, 4'hA}) srca = e.ra;
    if (e.icode inside {4'h9, 4'hB})             srca = 4'h4;
    if (e.icode inside {4'h4, 4'h5, 4'h6})       srcb = e.rb;
    if (e.icode inside {4'h8, 4'h9, 4'hA, 4'hB}) srcb = 4'h4;
    e.vala = rd(srca);
    e.valb = rd(srcb);

    lt = m_sf ^ m_of;
    e.cnd = 1'b0;
    if (e.icode inside {4'h2, 4'h7}) begin
      case (e.ifun)
        4'd0: e.cnd = 1'b1;
        4'd1: e.cnd = lt | m_zf;
        4'd2: e.cnd = lt;
        4'd3: e.cnd = m_zf;
        4'd4: e.cnd = !m_zf;
        4'd5: e.cnd = !lt;
        4'd6: e.cnd = !lt && !m_zf;
        default: e.cnd = 1'b0;
      endcase
    end

    sa  = e.vala;
    sbv = e.valb;
    e.vale   = 64'd0;
    e.new_of = 1'b0;
    case (e.icode)
      4'h2: e.vale = e.vala;
      4'h3: e.vale = e.valc;
      4'h4, 4'h5: e.vale = e.valb + e.valc;
      4'h6: begin
        if (e.ifun == 4'd0) begin
          r = sbv + sa;
          e.vale = r;
          e.new_of = ((sa < 0) == (sbv < 0)) && ((r < 0) != (sa < 0));
        end else if (e.ifun == 4'd1) begin
          r = sbv - sa;
          e.vale = r;
          e.new_of = ((sa < 0) != (sbv < 0)) && ((r < 0) != (sbv < 0));
        end else if (e.ifun == 4'd2) e.vale = e.valb & e.vala;
        else if (e.ifun == 4'd3)     e.vale = e.valb ^ e.vala;
      end
      4'h8, 4'hA: e.vale = e.valb - 64'd8;
      4'h9, 4'hB: e.vale = e.valb + 64'd8;
      default: ;
    endcase

    e.dste = 4'hF;
    if (e.icode inside {4'h3, 4'h6})             e.dste = e.rb;
    if (e.icode == 4'h2 && e.cnd)                e.dste = e.rb;
    if (e.icode inside {4'h8, 4'h9, 4'hA, 4'hB}) e.dste = 4'h4;
    e.dstm = (e.icode inside {4'h5, 4'hB}) ? e.ra : 4'hF;
    e.zf = m_zf;
    e.sf = m_sf;
    e.of = m_of;
    return e;
  endfunction

  task automatic model_edge(input exp_t e, input logic we, input logic [3:0] de,
                            input logic [63:0] ve, input logic [3:0] dm, input logic [63:0] vm);
    if (e.icode == 4'h6 && !e.inv && !e.imem && !e.hlt) begin
      m_zf = (e.vale == 64'd0);
      m_sf = e.vale[63];
      m_of = e.new_of;
    end
    if (we) begin
      if (de != 4'hF) m_regs[de] = ve;
      if (dm != 4'hF) m_regs[dm] = vm;
    end
  endtask

  // Drives one instruction for one cycle; optionally pulls reset mid-cycle.
  task automatic apply(input logic [63:0] pc_v, input logic [79:0] bv, input logic we,
                       input logic [3:0] de, input logic [63:0] ve,
                       input logic [3:0] dm, input logic [63:0] vm, input bit rst_mid);
    exp_t e;
    rst_n          = 1'b1;
    bus.pc         = pc_v;
    bus.imem_bytes = bv;
    bus.wb_en      = we;
    bus.wb_dstE    = de;
    bus.wb_valE    = ve;
    bus.wb_dstM    = dm;
    bus.wb_valM    = vm;
    if (rst_mid) begin
      #1;
      rst_n = 1'b0;
      model_reset();
    end
    e = model(pc_v, bv);
    sb.push_back(e);
    @(posedge clk);
    if (rst_n) model_edge(e, we, de, ve, dm, vm);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (vector %0d)", name, act, exp, vectors);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      vectors++;
      check("icode", 64'(bus.icode), 64'(mon_e.icode));
      check("ifun", 64'(bus.ifun), 64'(mon_e.ifun));
      check("rA", 64'(bus.rA), 64'(mon_e.ra));
      check("rB", 64'(bus.rB), 64'(mon_e.rb));
      check("valC", bus.valC, mon_e.valc);
      check("valP", bus.valP, mon_e.valp);
      check("instr_invalid", 64'(bus.instr_invalid), 64'(mon_e.inv));
      check("imem_er", 64'(bus.imem_er), 64'(mon_e.imem));
      check("hlt_er", 64'(bus.hlt_er), 64'(mon_e.hlt));
      check("valA", bus.valA, mon_e.vala);
      check("valB", bus.valB, mon_e.valb);
      check("dstE", 64'(bus.dstE), 64'(mon_e.dste));
      check("dstM", 64'(bus.dstM), 64'(mon_e.dstm));
      check("valE", bus.valE, mon_e.vale);
      check("cnd", 64'(bus.cnd), 64'(mon_e.cnd));
      check("zf", 64'(bus.zf), 64'(mon_e.zf));
      check("sf", 64'(bus.sf), 64'(mon_e.sf));
      check("of", 64'(bus.of), 64'(mon_e.of));
    end
  end

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [79:0] op1(input logic [7:0] b0);
    return {rnd64(), 8'($urandom), b0};
  endfunction

  function automatic logic [79:0] op2(input logic [7:0] b0, input logic [7:0] b1);
    return {rnd64(), b1, b0};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got %0d vectors", vectors);
    $fatal(1, "watchdog");
  end

  localparam logic [63:0] BIGP = 64'h7FFF_FFFF_FFFF_FFFF;

  initial begin
    logic [3:0] ic, fn;
    logic [63:0] pcr;
    int sel;
    rst_n          = 1'b0;
    bus.pc         = 64'd0;
    bus.imem_bytes = 80'd0;
    bus.wb_en      = 1'b0;
    bus.wb_dstE    = 4'hF;
    bus.wb_dstM    = 4'hF;
    bus.wb_valE    = 64'd0;
    bus.wb_valM    = 64'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;

    // irmovq $10, %rax with a write-back pulse, then rrmovq %rax, %rcx
    apply(64'd0, 80'h0000_0000_0000_000A_F030, 1'b1, 4'h0, 64'd10, 4'hF, 64'd0, 1'b0);
    apply(64'd10, op2(8'h20, 8'h01), 1'b0, 4'hF, 64'd0, 4'hF, 64'd0, 1'b0);

    // subq %rax,%rbx with rax=5, rbx=7; then je / jne
    apply(64'd12, op1(8'h10), 1'b1, 4'h0, 64'd5, 4'h3, 64'd7, 1'b0);
    apply(64'd13, op2(8'h61, 8'h03), 1'b0, 4'hF, 64'd0, 4'hF, 64'd0, 1'b0);
    apply(64'h40, op1(8'h73), 1'b0, 4'hF, 64'd0, 4'hF, 64'd0, 1'b0);
    apply(64'h49, op1(8'h74), 1'b0, 4'hF, 64'd0, 4'hF, 64'd0, 1'b0);

    // signed overflow on addq
    apply(64'h60, op1(8'h10), 1'b1, 4'h0, BIGP, 4'h3, BIGP, 1'b0);
    apply(64'h61, op2(8'h60, 8'h03), 1'b0, 4'hF, 64'd0, 4'hF, 64'd0, 1'b0);
    apply(64'h63, op1(8'h71), 1'b0, 4'hF, 64'd0, 4'hF, 64'd0, 1'b0);

    // stack: call, ret, popq %rsp with equal destinations, ret again
    apply(64'h80, op1(8'h10), 1'b1, 4'h4, 64'h100, 4'hF, 64'd0, 1'b0);
    apply(64'h81, op1(8'h80), 1'b0, 4'hF, 64'd0, 4'hF, 64'd0, 1'b0);
    apply(64'h8A, op1(8'h90), 1'b0, 4'hF, 64'd0, 4'hF, 64'd0, 1'b0);
    apply(64'h8B, op2(8'hB0, 8'h4F), 1'b1, 4'h4, 64'h108, 4'h4, 64'h55, 1'b0);
    apply(64'h8D, op1(8'h90), 1'b0, 4'hF, 64'd0, 4'hF, 64'd0, 1'b0);

    // halt, bad icode, bad ifun, address boundary
    apply(64'h90, op1(8'h00), 1'b0, 4'hF, 64'd0, 4'hF, 64'd0, 1'b0);
    apply(64'h91, op1(8'hC0), 1'b0, 4'hF, 64'd0, 4'hF, 64'd0, 1'b0);
    apply(64'h92, op2(8'h27, 8'h01), 1'b0, 4'hF, 64'd0, 4'hF, 64'd0, 1'b0);
    apply(64'd2047, op1(8'h10), 1'b0, 4'hF, 64'd0, 4'hF, 64'd0, 1'b0);
    apply(64'd2048, op1(8'h10), 1'b0, 4'hF, 64'd0, 4'hF, 64'd0, 1'b0);
    apply(64'd2048, op2(8'h60, 8'h03), 1'b0, 4'hF, 64'd0, 4'hF, 64'd0, 1'b0);

    // asynchronous reset with live state
    apply(64'hA0, op1(8'h10), 1'b1, 4'h4, 64'h1234, 4'h0, 64'h99, 1'b0);
    apply(64'hA1, op2(8'h61, 8'h40), 1'b0, 4'hF, 64'd0, 4'hF, 64'd0, 1'b0);
    apply(64'hA3, op1(8'h90), 1'b0, 4'hF, 64'd0, 4'hF, 64'd0, 1'b1);
    apply(64'hA4, op2(8'h60, 8'h04), 1'b0, 4'hF, 64'd0, 4'hF, 64'd0, 1'b0);

    for (int n = 0; n < 400; n++) begin
      ic = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) != 0) begin
        if (ic inside {4'h2, 4'h7}) fn = 4'($urandom_range(0, 6));
        else if (ic == 4'h6)        fn = 4'($urandom_range(0, 3));
        else                        fn = 4'h0;
      end else begin
        fn = 4'($urandom_range(0, 15));
      end
      sel = $urandom_range(0, 9);
      if (sel == 0)      pcr = 64'd2046 + 64'($urandom_range(0, 3));
      else if (sel == 1) pcr = rnd64();
      else               pcr = 64'($urandom_range(0, 2047));
      apply(pcr, {rnd64(), 8'($urandom), ic, fn},
            1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)),
            ($urandom_range(0, 1) != 0) ? 64'($urandom_range(0, 3)) : rnd64(),
            4'($urandom_range(0, 15)),
            ($urandom_range(0, 1) != 0) ? 64'($urandom_range(0, 3)) : rnd64(),
            ($urandom_range(0, 49) == 0));
    end

    repeat (2) @(posedge clk);
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending entries expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/y86_fetch_decode_exec.md
Name: y86_fetch_decode_exec

Overview:
Combined fetch, decode and execute front-end of a single-cycle sequential Y86-64 core.
- Fetch: parses the instruction bytes at PC.
- Decode: reads a 15-entry register file owned by this block.
- Execute: ALU plus registered condition codes, producing valE and cnd.
- Memory, write-back and PC-update stages sit outside the block. Write-back drives this block's register-file write port.

Parameters:
IMEM_BYTES, 2048, instruction-memory size in bytes; PC at or above this value is an address error.

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  asynchronous active-low reset
pc  in  64  current program counter
imem_bytes  in  80  10 instruction bytes starting at pc; byte k = bits [8k+7:8k]
icode, ifun  out  4 each  byte0[7:4], byte0[3:0]
rA, rB  out  4 each  register specifiers; 0xF when absent
valC  out  64  constant, little-endian
valP  out  64  fall-through PC
instr_invalid  out  1  illegal icode/ifun
imem_er  out  1  pc >= IMEM_BYTES
hlt_er  out  1  icode==0 (halt)
valA, valB  out  64  decoded operands
dstE, dstM  out  4  write-back destinations (0xF = none)
valE  out  64  ALU result
cnd  out  1  condition result
zf, sf, of  out  1 each  current condition codes
wb_en  in  1  register-file write enable
wb_dstE, wb_dstM  in  4 each  write destinations
wb_valE, wb_valM  in  64 each  write data

Behaviour:
- Fetch, decode and execute are fully combinational from pc, imem_bytes and current state.
- Needs reg byte: icode in {2,3,4,5,6,A,B}. Needs valC: icode in {3,4,5,7,8}.
- valC source: bytes 2..9 when a reg byte is present, else bytes 1..8.
- valP = pc + 1 + needreg + 8*needvalC, 64-bit wrapping.
- rA, rB = 0xF when there is no reg byte. valC = 0 when not needed.
- instr_invalid when any of:
  - icode > 0xB;
  - ifun != 0 for icode in {0,1,3,4,5,8,9,A,B};
  - ifun > 3 for icode 6;
  - ifun > 6 for icode 2 or 7.
- Register file: 15 x 64-bit, indices 0..14, index 4 = %rsp.
- srcA: rA for icode {2,4,6,A}; 4 for {9,B}; else 0xF.
- srcB: rB for {4,5,6}; 4 for {8,9,A,B}; else 0xF.
- Register reads are combinational with no bypass. Reading 0xF returns 0.
- dstE: rB for {3,6}; rB if cnd else 0xF for icode 2; 4 for {8,9,A,B}; else 0xF.
- dstM: rA for {5,B}; else 0xF.
- valE by icode:
  - 2: valA.
  - 3: valC.
  - 4, 5: valB + valC.
  - 6: valB + valA, valB - valA, valB & valA, valB ^ valA for ifun 0..3.
  - 8, A: valB - 8.
  - 9, B: valB + 8.
  - otherwise: 0.
- All arithmetic is 64-bit modulo 2^64.
- cnd by ifun, for icode 2 or 7 only; 0 otherwise:
  - 0: 1.
  - 1: (sf^of)|zf.
  - 2: sf^of.
  - 3: zf.
  - 4: ~zf.
  - 5: ~(sf^of).
  - 6: ~(sf^of)&~zf.
- Condition-code update on the rising edge only when icode==6 and none of instr_invalid, imem_er, hlt_er is set.
  - zf = (valE==0); sf = valE[63].
  - of for add: operands same sign and result sign differs.
  - of for sub: valB and valA differ in sign and result sign differs from valB.
  - of = 0 for and/xor.
- cnd always uses the pre-edge condition codes.
- Register writes on the rising edge when wb_en=1:
  - wb_dstE gets wb_valE, then wb_dstM gets wb_valM. A destination of 0xF is ignored.
  - When both destinations are equal, the M write wins.
- Reset (asynchronous, rst_n=0): all registers = 0; zf=1, sf=0, of=0. Writes and CC updates are blocked while reset is asserted.
- Error outputs are independent; more than one may be set at once.

Test Plan:
1. Reset, pc=0, bytes 30 F0 0A 00.. -> icode=3, rB=0, valC=10, valP=10, valE=10, dstE=0, no errors. Then pulse wb_en with wb_dstE=0, wb_valE=10 -> next cycle bytes 20 01 read valA=10, valE=10, dstE=1 (cnd=1).
2. With regs rax=5, rbx=7, bytes 61 03 (subq rax,rbx) -> valE=2. After edge zf=0, sf=0, of=0. Then bytes 73 (je) -> cnd=0; 74 (jne) -> cnd=1. Verify valC from bytes 1..8 and valP=pc+9.
3. rax=rbx=0x7FFF_FFFF_FFFF_FFFF, addq (60 03) -> valE=0xFFFF_FFFF_FFFF_FFFE; after edge sf=1, of=1, zf=0.
4. rsp=0x100: call (80) -> valE=0xF8, dstE=4. ret (90) -> valA=valB=0x100, valE=0x108. popq rsp (B0 4F) with wb_dstE=wb_dstM=4, wb_valE=0x108, wb_valM=0x55 -> rsp becomes 0x55.
5. Byte 00 -> hlt_er=1 and CC unchanged. Byte C0 -> instr_invalid=1. Byte 27 -> instr_invalid=1. pc=2048 -> imem_er=1.
6. Assert rst_n low mid-run with nonzero regs and CC -> immediately regs read 0 and zf=1, sf=0, of=0, without waiting for a clock edge.
